// File: rtl/signed_add_acc_pkg.sv
// Shared parameters for the signed add/accumulate pipeline: default operand
// width and the overflow policy encodings.
package signed_add_acc_pkg;

    // Default operand magnitude width; the result width defaults to this plus 2.
    localparam int DEF_W = 4;

    // Overflow policy encodings for the SAT parameter.
    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;
    localparam int DEF_SAT   = SAT_WRAP;

endpackage

// File: rtl/signed_add_acc_if.sv
// Valid/ready bus of the signed add/accumulate block: operand transaction
// going in, signed result with overflow flag coming out.
interface signed_add_acc_if import signed_add_acc_pkg::*; #(
    parameter int W  = DEF_W,
    parameter int OW = W + 2
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         a;
    logic [W-1:0]         b;
    logic                 nega;
    logic                 negb;
    logic                 acc_en;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] sum;
    logic                 ovf;

    // Producer of transactions and consumer of results.
    modport master (
        output in_valid, a, b, nega, negb, acc_en, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    // The arithmetic block itself.
    modport slave (
        input  in_valid, a, b, nega, negb, acc_en, out_ready,
        output in_ready, out_valid, sum, ovf
    );

endinterface

// File: rtl/signed_add_acc_negate.sv
// Conditional negation of an unsigned magnitude into a sign-extended
// OW+2-bit two's-complement operand. Negating zero yields zero.
module cond_negate import signed_add_acc_pkg::*; #(
    parameter int W  = DEF_W,
    parameter int OW = W + 2
) (
    input  logic [W-1:0]         magnitude,
    input  logic                 neg,
    output logic signed [OW+1:0] result
);

    logic signed [OW+1:0] mag_ext;

    assign mag_ext = {{(OW + 2 - W){1'b0}}, magnitude};
    assign result  = neg ? -mag_ext : mag_ext;

endmodule

// File: rtl/signed_add_acc.sv
// Two-stage signed add/accumulate pipeline with valid/ready flow control.
// Stage 1 registers the conditionally negated operands; stage 2 adds them,
// optionally with the previous result, and wraps or clamps on overflow.
module signed_add_acc import signed_add_acc_pkg::*; #(
    parameter int W   = DEF_W,
    parameter int OW  = W + 2,
    parameter int SAT = DEF_SAT
) (
    input  logic         clk,
    input  logic         rst_n,
    signed_add_acc_if.slave bus
);

    // A result narrower than W+1 bits cannot even hold a single operand.
    if (OW < W + 1) begin : g_bad_ow
        $error("signed_add_acc: OW must be at least W+1");
    end

    // Range limits of the OW-bit result, expressed in the OW+2-bit sum width.
    localparam logic signed [OW+1:0] T_MAX   = {3'b000, {(OW - 1){1'b1}}};
    localparam logic signed [OW+1:0] T_MIN   = {3'b111, {(OW - 1){1'b0}}};
    localparam logic signed [OW-1:0] SUM_MAX = {1'b0, {(OW - 1){1'b1}}};
    localparam logic signed [OW-1:0] SUM_MIN = {1'b1, {(OW - 1){1'b0}}};

    logic signed [OW+1:0] opa_d;
    logic signed [OW+1:0] opb_d;

    logic                 s1_valid;
    logic signed [OW+1:0] s1_opa;
    logic signed [OW+1:0] s1_opb;
    logic                 s1_acc_en;

    // The output register doubles as the accumulator: acc is by definition
    // the last produced sum, so a back-to-back dependent transaction sees
    // its predecessor's result with no bubble.
    logic                 out_valid_q;
    logic signed [OW-1:0] sum_q;
    logic                 ovf_q;

    logic                 adv1;
    logic                 adv2;
    logic signed [OW+1:0] acc_ext;
    logic signed [OW+1:0] t;
    logic                 t_ovf;
    logic signed [OW-1:0] t_sum;

    cond_negate #(.W(W), .OW(OW)) u_neg_a (
        .magnitude (bus.a),
        .neg       (bus.nega),
        .result    (opa_d)
    );

    cond_negate #(.W(W), .OW(OW)) u_neg_b (
        .magnitude (bus.b),
        .neg       (bus.negb),
        .result    (opb_d)
    );

    // Stage 2 moves when its register is empty or being drained; stage 1
    // moves when stage 2 can take its content. No skid buffer, so in_ready
    // is combinational from out_ready, and held low throughout reset.
    assign adv2         = !out_valid_q || bus.out_ready;
    assign adv1         = !s1_valid || adv2;
    assign bus.in_ready = rst_n && adv1;

    assign acc_ext = {{2{sum_q[OW-1]}}, sum_q};

    // Exact sum, overflow detection and wrap/clamp selection.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        t     = s1_opa + s1_opb + (s1_acc_en ? acc_ext : '0);
        t_ovf = (t > T_MAX) || (t < T_MIN);
        t_sum = t[OW-1:0];
        if ((SAT == SAT_CLAMP) && t_ovf) begin
            t_sum = t[OW+1] ? SUM_MIN : SUM_MAX;
        end
    end

    // Stage 1: capture the signed operands on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state is written with non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_opa    <= '0;
            s1_opb    <= '0;
            s1_acc_en <= 1'b0;
        end else if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_opa    <= opa_d;
                s1_opb    <= opb_d;
                s1_acc_en <= bus.acc_en;
            end
        end
    end

    // Stage 2: register the result (and thereby the accumulator).
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sum_q is reset as well as the valid bit because it is also
        // the accumulator; a stale value would leak into the first Acc_En.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
        end else if (adv2) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                sum_q <= t_sum;
                ovf_q <= t_ovf;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.ovf       = ovf_q;

endmodule
